// File: rtl/trigger_pkg.sv
// Shared definitions for the edge trigger array.
//   edge_mode_e : per-channel edge select (OFF / RISE / FALL / BOTH)
//   edge_match  : does a level transition to new_level qualify under mode m
package trigger_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic logic edge_match(edge_mode_e m, logic new_level);
    logic rise_en;
    logic fall_en;
    rise_en = (m == EDGE_RISE) || (m == EDGE_BOTH);
    fall_en = (m == EDGE_FALL) || (m == EDGE_BOTH);
    return new_level ? rise_en : fall_en;
  endfunction

endpackage

// File: rtl/edge_trigger_chan.sv
// One input channel: synchroniser, debouncer, edge qualifier, sticky flags.
//   clk, rst   : clock, asynchronous active-high reset
//   signal_in  : raw asynchronous input
//   mode       : edge select (see trigger_pkg::edge_mode_e), sampled every cycle
//   clear      : 1-cycle strobe clearing event_flag / overrun
//   level_out  : debounced level
//   pulse_out  : 1-clk pulse on a qualifying debounced edge
//   event_flag : sticky "edge seen"
//   overrun    : sticky "edge seen while event_flag still set"
module edge_trigger_chan
  import trigger_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal_in,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       level_out,
  output logic       pulse_out,
  output logic       event_flag,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   accept;
  logic                   pulse_set;
  edge_mode_e             mode_e;

  assign s      = sync_q[SYNC_STAGES-1];
  assign mode_e = edge_mode_e'(mode);

  // accept fires on the DEBOUNCE_CYCLES-th consecutive sample differing
  // from the current level; pulse_set is the next value of pulse_out.
  always_comb begin
    accept    = 1'b0;
    pulse_set = 1'b0;
    if ((s != level_out) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1))) begin
      accept    = 1'b1;
      pulse_set = edge_match(mode_e, s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      cnt        <= '0;
      level_out  <= 1'b0;
      pulse_out  <= 1'b0;
      event_flag <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};

      if (s == level_out) begin
        cnt <= '0;
      end else if (accept) begin
        level_out <= s;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      pulse_out <= pulse_set;
      // A set coinciding with clear wins for event_flag; overrun only
      // records an edge landing on a flag that was not being cleared.
      event_flag <= pulse_set | (event_flag & ~clear);
      overrun    <= (pulse_set & event_flag & ~clear) | (overrun & ~clear);
    end
  end

endmodule

// File: rtl/edge_trigger_array.sv
// Multi-channel input conditioner and edge trigger.
//   clk, rst   : clock, asynchronous active-high reset
//   signal_in  : raw asynchronous inputs, one per channel
//   mode       : per-channel edge select, channel i = mode[2i+1:2i]
//   clear      : per-channel clear strobe for event_flag / overrun
//   level_out  : debounced levels
//   pulse_out  : 1-clk edge pulses
//   event_flag : sticky edge-seen flags
//   overrun    : sticky overrun flags
//   any_pulse  : OR of pulse_out
module edge_trigger_array
  import trigger_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   signal_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic [CHANNELS-1:0]   event_flag,
  output logic [CHANNELS-1:0]   overrun,
  output logic                  any_pulse
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_trigger_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .signal_in  (signal_in[i]),
      .mode       (mode[2*i +: 2]),
      .clear      (clear[i]),
      .level_out  (level_out[i]),
      .pulse_out  (pulse_out[i]),
      .event_flag (event_flag[i]),
      .overrun    (overrun[i])
    );
  end

  assign any_pulse = |pulse_out;

endmodule

// File: tb/tb_edge_trigger_array.sv
module tb_edge_trigger_array;

  localparam int CH = 4;
  localparam int S  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] signal_in = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0] clear = '0;
  logic [CH-1:0] level_out, pulse_out, event_flag, overrun;
  logic          any_pulse;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  edge_trigger_array #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .signal_in  (signal_in),
    .mode       (mode),
    .clear      (clear),
    .level_out  (level_out),
    .pulse_out  (pulse_out),
    .event_flag (event_flag),
    .overrun    (overrun),
    .any_pulse  (any_pulse)
  );

  // Reference model: keeps the history of raw samples taken at each edge.
  // The value the conditioner acts on at edge n is the sample from edge n-S;
  // a new level is accepted once the last D such values all differ from it.
  logic [15:0]   m_hist [CH];
  logic [CH-1:0] m_lvl = '0, m_pul = '0, m_ev = '0, m_ov = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) m_hist[c] <= '0;
      m_lvl <= '0;
      m_pul <= '0;
      m_ev  <= '0;
      m_ov  <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        logic acc, newl, p;
        logic [1:0] md;
        acc = 1'b1;
        for (int k = S - 1; k <= S + D - 2; k++)
          if (m_hist[c][k] == m_lvl[c]) acc = 1'b0;
        newl = acc ? ~m_lvl[c] : m_lvl[c];
        md   = mode[2*c +: 2];
        p    = acc && (newl ? md[0] : md[1]);
        m_pul[c]  <= p;
        m_lvl[c]  <= newl;
        m_ov[c]   <= (p & m_ev[c] & ~clear[c]) | (m_ov[c] & ~clear[c]);
        m_ev[c]   <= p | (m_ev[c] & ~clear[c]);
        m_hist[c] <= {m_hist[c][14:0], signal_in[c]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_level", 32'(level_out),  32'(m_lvl));
    chk("model_pulse", 32'(pulse_out),  32'(m_pul));
    chk("model_event", 32'(event_flag), 32'(m_ev));
    chk("model_ovr",   32'(overrun),    32'(m_ov));
    chk("model_any",   32'(any_pulse),  32'(|m_pul));
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
  endtask

  int pc;

  initial begin
    // 1. reset and idle
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) step();
    chk("idle_level", 32'(level_out),  32'h0);
    chk("idle_pulse", 32'(pulse_out),  32'h0);
    chk("idle_event", 32'(event_flag), 32'h0);
    chk("idle_ovr",   32'(overrun),    32'h0);

    // 2. ch0 RISE latency: pulse and level exactly S+D edges later
    mode = 8'h01;
    signal_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("lat_pulse_%0d", k), 32'(pulse_out[0]), 32'(k == 6));
      chk($sformatf("lat_level_%0d", k), 32'(level_out[0]), 32'(k == 6));
    end
    step();
    chk("lat_pulse_off", 32'(pulse_out[0]),  32'h0);
    chk("lat_event",     32'(event_flag[0]), 32'h1);

    // 3. ch1 glitch of D-1 cycles is ignored, D cycles is accepted
    mode = 8'h05;
    pc = 0;
    signal_in[1] = 1'b1;
    repeat (3) begin step(); pc += int'(pulse_out[1]); end
    signal_in[1] = 1'b0;
    repeat (12) begin step(); pc += int'(pulse_out[1]); chk("glitch_level", 32'(level_out[1]), 32'h0); end
    chk("glitch_pulses", 32'(pc), 32'd0);
    signal_in[1] = 1'b1;
    repeat (4) begin step(); pc += int'(pulse_out[1]); end
    signal_in[1] = 1'b0;
    repeat (12) begin step(); pc += int'(pulse_out[1]); end
    chk("d_cycle_pulses", 32'(pc), 32'd1);

    // 4. ch2 FALL then BOTH
    mode = 8'h25;
    pc = 0; signal_in[2] = 1'b1;
    repeat (12) begin step(); pc += int'(pulse_out[2]); end
    chk("fall_rise_pulses", 32'(pc), 32'd0);
    pc = 0; signal_in[2] = 1'b0;
    repeat (12) begin step(); pc += int'(pulse_out[2]); end
    chk("fall_fall_pulses", 32'(pc), 32'd1);
    mode = 8'h35;
    pc = 0; signal_in[2] = 1'b1;
    repeat (12) begin step(); pc += int'(pulse_out[2]); end
    chk("both_rise_pulses", 32'(pc), 32'd1);
    pc = 0; signal_in[2] = 1'b0;
    repeat (12) begin step(); pc += int'(pulse_out[2]); end
    chk("both_fall_pulses", 32'(pc), 32'd1);

    // 5. ch3 overrun, clear, clear coincident with pulse
    clear = '1; step(); clear = '0;
    mode = 8'h55;
    signal_in[3] = 1'b1; repeat (12) step();
    signal_in[3] = 1'b0; repeat (12) step();
    signal_in[3] = 1'b1; repeat (12) step();
    chk("ovr_event", 32'(event_flag[3]), 32'h1);
    chk("ovr_set",   32'(overrun[3]),    32'h1);
    clear[3] = 1'b1; step(); clear[3] = 1'b0; step();
    chk("clr_event", 32'(event_flag[3]), 32'h0);
    chk("clr_ovr",   32'(overrun[3]),    32'h0);
    signal_in[3] = 1'b0; repeat (12) step();
    signal_in[3] = 1'b1; repeat (12) step();
    signal_in[3] = 1'b0; repeat (12) step();
    chk("pre_coinc_event", 32'(event_flag[3]), 32'h1);
    signal_in[3] = 1'b1;
    repeat (5) step();
    clear[3] = 1'b1; step(); clear[3] = 1'b0;
    chk("coinc_pulse", 32'(pulse_out[3]),  32'h1);
    chk("coinc_event", 32'(event_flag[3]), 32'h1);
    chk("coinc_ovr",   32'(overrun[3]),    32'h0);

    // 6. simultaneous edges on all channels, then one channel OFF
    clear = '1; signal_in = '0; step(); clear = '0;
    repeat (12) step();
    signal_in = '1;
    repeat (5) step();
    chk("sim_pre_pulse", 32'(pulse_out), 32'h0);
    step();
    chk("sim_pulse", 32'(pulse_out), 32'hF);
    chk("sim_any",   32'(any_pulse), 32'h1);
    step();
    chk("sim_any_off", 32'(any_pulse), 32'h0);
    mode = 8'h51;
    signal_in = '0; repeat (12) step();
    signal_in = '1; repeat (6) step();
    chk("off_pulse", 32'(pulse_out), 32'hD);
    chk("off_level", 32'(level_out), 32'hF);

    // 7. randomized stimulus against the model
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 9) == 0) signal_in[c] = ~signal_in[c];
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      clear = ($urandom_range(0, 19) == 0) ? 4'($urandom) : '0;
      step();
    end
    clear = '0;

    // 8. asynchronous reset in the middle of a debounce
    signal_in = ~level_out;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_level", 32'(level_out),  32'h0);
    chk("arst_pulse", 32'(pulse_out),  32'h0);
    chk("arst_event", 32'(event_flag), 32'h0);
    chk("arst_ovr",   32'(overrun),    32'h0);
    chk("arst_any",   32'(any_pulse),  32'h0);
    check_model();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
